// File: rtl/debug_input_conditioner_pkg.sv
// Shared types, default timing and counter sizing for the debugger input conditioner.
package debug_input_conditioner_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t KEY_IDLE         = 2'd0;
    localparam key_state_t KEY_PRESS_WAIT   = 2'd1;
    localparam key_state_t KEY_HELD         = 2'd2;
    localparam key_state_t KEY_RELEASE_WAIT = 2'd3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_SW_WIDTH        = 10;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/debug_input_conditioner_key_debouncer.sv
// Synchronizes and debounces one active-low key; emits one-cycle press/release events.
module key_debouncer
    import debug_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = cnt_width(DEF_REPEAT_DELAY)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output key_state_t state,
    output logic       held,
    output logic       press_evt,
    output logic       release_evt
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;

    // The counter never passes DB_LAST: both wait states leave on reaching it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            state    <= KEY_IDLE;
            cnt      <= '0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            case (state)
                KEY_IDLE: begin
                    if (!key_sync) begin
                        state <= KEY_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                KEY_PRESS_WAIT: begin
                    if (key_sync)            state <= KEY_IDLE;
                    else if (cnt == DB_LAST) state <= KEY_HELD;
                    else                     cnt   <= cnt + 1'b1;
                end
                KEY_HELD: begin
                    if (key_sync) begin
                        state <= KEY_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                KEY_RELEASE_WAIT: begin
                    if (!key_sync)           state <= KEY_HELD;
                    else if (cnt == DB_LAST) state <= KEY_IDLE;
                    else                     cnt   <= cnt + 1'b1;
                end
                default: state <= KEY_IDLE;
            endcase
        end
    end

    always_comb begin
        press_evt   = (state == KEY_PRESS_WAIT) && !key_sync && (cnt == DB_LAST);
        release_evt = (state == KEY_RELEASE_WAIT) && key_sync && (cnt == DB_LAST);
        held        = (state == KEY_HELD) || (state == KEY_RELEASE_WAIT);
    end

endmodule

// File: rtl/debug_input_conditioner.sv
// Debugger front end: debounced switch bus, step pulses with auto-repeat, run/step mode.
module debug_input_conditioner
    import debug_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned SW_WIDTH        = DEF_SW_WIDTH
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [SW_WIDTH-1:0] swRaw,
    input  logic                keyStepN,
    input  logic                keyRunN,
    output logic [SW_WIDTH-1:0] switches,
    output logic                stepPulse,
    output logic                runMode,
    output logic                stepHeld
);

    localparam int unsigned      CNT_W      = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                                             REPEAT_PERIOD));
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [SW_WIDTH-1:0] sw_cand;
    logic [CNT_W-1:0]    sw_cnt;
    logic [CNT_W-1:0]    rep_cnt;
    logic                rep_fire;

    key_state_t step_state;
    logic       step_press;
    logic       run_press;
    logic       unused_step_release;
    key_state_t unused_run_state;
    logic       unused_run_held;
    logic       unused_run_release;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step_key (
        .clk         (Clk),
        .rst_n       (Rst),
        .key_n       (keyStepN),
        .state       (step_state),
        .held        (stepHeld),
        .press_evt   (step_press),
        .release_evt (unused_step_release)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_run_key (
        .clk         (Clk),
        .rst_n       (Rst),
        .key_n       (keyRunN),
        .state       (unused_run_state),
        .held        (unused_run_held),
        .press_evt   (run_press),
        .release_evt (unused_run_release)
    );

    // One window for the whole bus so a multi-bit change is committed atomically.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_cand  <= '0;
            sw_cnt   <= '0;
            switches <= '0;
        end else begin
            sw_meta <= swRaw;
            sw_sync <= sw_meta;
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                sw_cnt  <= '0;
            end else if (sw_cnt != DB_LAST) begin
                sw_cnt <= sw_cnt + 1'b1;
            end
            if ((sw_cnt == DB_LAST) && (sw_cand != switches))
                switches <= sw_cand;
        end
    end

    assign rep_fire = (step_state == KEY_HELD) && (rep_cnt == REP_LAST);

    // Reloading to DELAY-PERIOD after each repeat yields the period spacing without a second counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rep_cnt   <= '0;
            stepPulse <= 1'b0;
            runMode   <= 1'b0;
        end else begin
            case (step_state)
                KEY_HELD:         rep_cnt <= rep_fire ? REP_RELOAD : rep_cnt + 1'b1;
                KEY_RELEASE_WAIT: rep_cnt <= rep_cnt;
                default:          rep_cnt <= '0;
            endcase
            stepPulse <= (step_press || rep_fire) && !runMode;
            runMode   <= runMode ^ run_press;
        end
    end

endmodule

// File: tb/tb_debug_input_conditioner.sv
// Directed self-checking bench for debug_input_conditioner with short timing parameters.
module tb_debug_input_conditioner;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [9:0] swRaw = '0;
    logic       keyStepN = 1'b1;
    logic       keyRunN = 1'b1;
    logic [9:0] switches;
    logic       stepPulse;
    logic       runMode;
    logic       stepHeld;

    int n_checks = 0;
    int n_errors = 0;

    debug_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .SW_WIDTH        (10)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .swRaw     (swRaw),
        .keyStepN  (keyStepN),
        .keyRunN   (keyRunN),
        .switches  (switches),
        .stepPulse (stepPulse),
        .runMode   (runMode),
        .stepHeld  (stepHeld)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        swRaw    = '0;
        keyStepN = 1'b1;
        keyRunN  = 1'b1;
        Rst      = 1'b0;
        #1;
        check("rst_switches", 32'(switches), 32'h0);
        check("rst_pulse", 32'(stepPulse), 32'h0);
        check("rst_run", 32'(runMode), 32'h0);
        check("rst_held", 32'(stepHeld), 32'h0);
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;
        repeat (8) @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [9:0] sw_bounce(input int i);
        return (i >= 20 || ((i / 2) % 2) == 0) ? 10'h200 : 10'h000;
    endfunction

    initial begin
        #2;
        do_reset();

        // Steady switch change: committed on the 6th edge after it is first sampled.
        swRaw = 10'h2A5;
        for (int i = 0; i <= 8; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t1_sw[%0d]", i), 32'(switches), (i >= 6) ? 32'h2A5 : 32'h0);
        end

        do_reset();
        swRaw = sw_bounce(0);
        for (int i = 0; i <= 30; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t2_sw[%0d]", i), 32'(switches), (i >= 26) ? 32'h200 : 32'h0);
            swRaw = sw_bounce(i + 1);
        end

        // Bounce on the second sample delays the press debounce by two cycles.
        do_reset();
        keyStepN = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t3_pulse[%0d]", i), 32'(stepPulse), 32'(i == 8));
            check($sformatf("t3_held[%0d]", i), 32'(stepHeld), 32'(i >= 8 && i <= 15));
            keyStepN = ((i + 1) == 1) || ((i + 1) >= 10);
        end

        do_reset();
        keyStepN = 1'b0;
        for (int i = 0; i <= 60; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t4_pulse[%0d]", i), 32'(stepPulse),
                  32'(i == 6 || i == 26 || i == 34 || i == 42 || i == 50));
            check($sformatf("t4_held[%0d]", i), 32'(stepHeld), 32'(i >= 6 && i <= 55));
            keyStepN = ((i + 1) >= 50);
        end

        do_reset();
        keyRunN = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t5a_run[%0d]", i), 32'(runMode), 32'(i >= 6));
            keyRunN = ((i + 1) >= 10);
        end
        keyStepN = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t5b_pulse[%0d]", i), 32'(stepPulse), 32'h0);
            check($sformatf("t5b_held[%0d]", i), 32'(stepHeld), 32'(i >= 6 && i <= 15));
            check($sformatf("t5b_run[%0d]", i), 32'(runMode), 32'h1);
            keyStepN = ((i + 1) >= 10);
        end
        // Simultaneous run toggle and step press: pre-toggle mode decides masking.
        keyStepN = 1'b0;
        keyRunN  = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t5c_pulse[%0d]", i), 32'(stepPulse), 32'h0);
            check($sformatf("t5c_run[%0d]", i), 32'(runMode), 32'(i < 6));
            keyStepN = ((i + 1) >= 10);
            keyRunN  = ((i + 1) >= 10);
        end
        keyStepN = 1'b0;
        keyRunN  = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t5d_pulse[%0d]", i), 32'(stepPulse), 32'(i == 6));
            check($sformatf("t5d_run[%0d]", i), 32'(runMode), 32'(i >= 6));
            keyStepN = ((i + 1) >= 10);
            keyRunN  = ((i + 1) >= 10);
        end

        // Reset during the press pulse with the key still held.
        do_reset();
        swRaw    = 10'h3FF;
        keyStepN = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            @(posedge Clk); #1;
        end
        check("t6_pre_pulse", 32'(stepPulse), 32'h1);
        check("t6_pre_held", 32'(stepHeld), 32'h1);
        check("t6_pre_sw", 32'(switches), 32'h3FF);
        #1 Rst = 1'b0;
        #1;
        check("t6_async_pulse", 32'(stepPulse), 32'h0);
        check("t6_async_held", 32'(stepHeld), 32'h0);
        check("t6_async_sw", 32'(switches), 32'h0);
        check("t6_async_run", 32'(runMode), 32'h0);
        @(posedge Clk); #1;
        check("t6_rst_held2", 32'(stepHeld), 32'h0);
        Rst = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            @(posedge Clk); #1;
            check($sformatf("t6_pulse[%0d]", i), 32'(stepPulse), 32'(i == 6));
            check($sformatf("t6_held[%0d]", i), 32'(stepHeld), 32'(i >= 6));
            check($sformatf("t6_sw[%0d]", i), 32'(switches), (i >= 6) ? 32'h3FF : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
